// File: rtl/ucode_pkg.sv
// ucode_pkg: types and constants shared by the microcode sequencer.
//   state_e          - sequencer states (fetch, microstep, execution wait,
//                      end-of-step events, halted)
//   CW_HALT/PCC/LAST - bit positions inside the control word
//   FETCH_CW_DEFAULT - control word presented while an instruction is fetched
//                      (PC count enable plus ROM output enable)
package ucode_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_STEP   = 3'd1,
        S_WAIT   = 3'd2,
        S_EVENTS = 3'd3,
        S_HALTED = 3'd4
    } state_e;

    localparam int CW_PCC  = 20;
    localparam int CW_HALT = 21;
    localparam int CW_LAST = 22;

    localparam logic [23:0] FETCH_CW_DEFAULT = 24'h100200;

endpackage

// File: rtl/ucode_seq.sv
// ucode_seq: microcode sequencer. Fetches an instruction byte, then walks its
// microsteps through an external microcode ROM addressed by (ucode_ir,
// ucode_step). Each microstep is a STEP cycle, optional WAIT cycles for an
// execution-unit handshake, and one EVENTS cycle that commits results.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   ir_in           instruction byte from the memory bus
//   ucode_ir        registered instruction (ROM address, high part)
//   ucode_step      current microstep (ROM address, low part)
//   cw              control word from the external ROM
//   cw_out          active control word (FETCH_CW / 0 when halted / cw)
//   exec_req        execution unit request, high during WAIT
//   exec_done       execution complete, only looked at in WAIT
//   pc_load         jump taken, only looked at at end of instruction
//   pc_load_val     jump target
//   resume          leave the halted state
//   pc              program counter
//   write_en        register/memory commit strobe (EVENTS)
//   first_step      write_en on microstep 0 (high-bits write enable)
//   halted          high while halted
module ucode_seq
    import ucode_pkg::*;
#(
    parameter int                IR_W      = 8,
    parameter int                PC_W      = 16,
    parameter int                CW_W      = 24,
    parameter int                STEPS     = 4,
    parameter logic [CW_W-1:0]   EXEC_MASK = 24'h00001E,
    parameter logic [CW_W-1:0]   FETCH_CW  = FETCH_CW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IR_W-1:0]            ir_in,
    output logic [IR_W-1:0]            ucode_ir,
    output logic [$clog2(STEPS)-1:0]   ucode_step,
    input  logic [CW_W-1:0]            cw,
    output logic [CW_W-1:0]            cw_out,
    output logic                       exec_req,
    input  logic                       exec_done,
    input  logic                       pc_load,
    input  logic [PC_W-1:0]            pc_load_val,
    input  logic                       resume,
    output logic [PC_W-1:0]            pc,
    output logic                       write_en,
    output logic                       first_step,
    output logic                       halted
);

    localparam int                STEP_W    = $clog2(STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [STEP_W-1:0]   step_q, step_d;

    // Modulo-2^PC_W increment; the carry out is simply dropped.
    logic [PC_W-1:0]     pc_inc;
    logic                end_of_instr;

    assign pc_inc       = pc_q + PC_W'(1);
    assign end_of_instr = cw[CW_LAST] || (step_q == LAST_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        step_d     = step_q;
        cw_out     = cw;
        exec_req   = 1'b0;
        write_en   = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                cw_out  = FETCH_CW;
                ir_d    = ir_in;
                step_d  = '0;
                state_d = S_STEP;
            end
            S_STEP: begin
                // HALT wins over PCC and the exec handshake.
                if (cw[CW_HALT]) begin
                    state_d = S_HALTED;
                end else begin
                    if (cw[CW_PCC]) begin
                        pc_d = pc_inc;
                    end
                    state_d = ((cw & EXEC_MASK) != '0) ? S_WAIT : S_EVENTS;
                end
            end
            S_WAIT: begin
                exec_req = 1'b1;
                if (exec_done) begin
                    state_d = S_EVENTS;
                end
            end
            S_EVENTS: begin
                write_en = 1'b1;
                if (end_of_instr) begin
                    pc_d    = pc_load ? pc_load_val : pc_inc;
                    state_d = S_FETCH;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = S_STEP;
                end
            end
            S_HALTED: begin
                halted = 1'b1;
                cw_out = '0;
                if (resume) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign first_step = write_en && (step_q == '0);
    assign ucode_ir   = ir_q;
    assign ucode_step = step_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_ucode_seq.sv
// tb_ucode_seq: self-checking bench for ucode_seq. A table of whole
// instructions (microcode per step, WAIT length, jump) is run on the default
// instance, followed by hand-written HALT/resume and reset-in-WAIT sequences,
// and an 8-step instruction on a second instance built with STEPS=8.
module tb_ucode_seq;
    import ucode_pkg::*;

    localparam logic [23:0] C_LAST = 24'h400000;
    localparam logic [23:0] C_HALT = 24'h200000;
    localparam logic [23:0] C_PCC  = 24'h100000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance signals
    logic        rst = 1'b1;
    logic [7:0]  ir_in = '0;
    logic [7:0]  ucode_ir;
    logic [1:0]  ucode_step;
    logic [23:0] cw;
    logic [23:0] cw_out;
    logic        exec_req;
    logic        exec_done = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = '0;
    logic        resume = 1'b0;
    logic [15:0] pc;
    logic        write_en;
    logic        first_step;
    logic        halted;

    // Microcode ROM model: one control word per step of the current instruction
    logic [3:0][23:0] rom_cw = '0;
    assign cw = rom_cw[ucode_step];

    ucode_seq dut (
        .clk        (clk),
        .rst        (rst),
        .ir_in      (ir_in),
        .ucode_ir   (ucode_ir),
        .ucode_step (ucode_step),
        .cw         (cw),
        .cw_out     (cw_out),
        .exec_req   (exec_req),
        .exec_done  (exec_done),
        .pc_load    (pc_load),
        .pc_load_val(pc_load_val),
        .resume     (resume),
        .pc         (pc),
        .write_en   (write_en),
        .first_step (first_step),
        .halted     (halted)
    );

    // STEPS=8 instance signals
    logic        rst8 = 1'b1;
    logic [7:0]  ir_in8 = 8'h5A;
    logic [7:0]  ucode_ir8;
    logic [2:0]  ucode_step8;
    logic [23:0] cw8 = '0;
    logic [23:0] cw_out8;
    logic        exec_req8;
    logic        exec_done8 = 1'b0;
    logic        pc_load8 = 1'b0;
    logic [15:0] pc_load_val8 = '0;
    logic        resume8 = 1'b0;
    logic [15:0] pc8;
    logic        write_en8;
    logic        first_step8;
    logic        halted8;

    ucode_seq #(.STEPS(8)) dut8 (
        .clk        (clk),
        .rst        (rst8),
        .ir_in      (ir_in8),
        .ucode_ir   (ucode_ir8),
        .ucode_step (ucode_step8),
        .cw         (cw8),
        .cw_out     (cw_out8),
        .exec_req   (exec_req8),
        .exec_done  (exec_done8),
        .pc_load    (pc_load8),
        .pc_load_val(pc_load_val8),
        .resume     (resume8),
        .pc         (pc8),
        .write_en   (write_en8),
        .first_step (first_step8),
        .halted     (halted8)
    );

    int n_total  = 0;
    int n_passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_passed++;
        end
    endtask

    // One instruction: ROM contents, WAIT length, jump, and hand-computed
    // results. Masks have bit N set when the strobe is high in cycle N, where
    // cycle 1 is the FETCH cycle.
    typedef struct {
        logic [7:0]        ir;
        logic [3:0][23:0]  cws;       // {step3, step2, step1, step0}
        int                waits;     // WAIT cycles before exec_done is seen
        logic              jmp;
        logic [15:0]       jmp_val;
        logic [15:0]       exp_pc;
        int                exp_lat;
        logic [31:0]       exp_we;
        logic [31:0]       exp_fs;
        int                exp_exec;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input int idx);
        vec_t        v;
        int          cyc;
        int          exec_cnt;
        logic [31:0] we_mask;
        logic [31:0] fs_mask;
        logic        timed_out;
        v           = vecs[idx];
        ir_in       = v.ir;
        rom_cw      = v.cws;
        pc_load     = v.jmp;
        pc_load_val = v.jmp_val;
        exec_done   = 1'b0;
        cyc         = 1;
        exec_cnt    = 0;
        we_mask     = '0;
        fs_mask     = '0;
        timed_out   = 1'b0;
        while (1) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cw_out == FETCH_CW_DEFAULT) break;
            if (cyc > 30) begin
                timed_out = 1'b1;
                break;
            end
            if (cyc == 2) check($sformatf("v%0d_ir", idx), 32'(ucode_ir), 32'(v.ir));
            if (write_en)   we_mask[cyc] = 1'b1;
            if (first_step) fs_mask[cyc] = 1'b1;
            if (exec_req) begin
                exec_cnt++;
                exec_done = (exec_cnt >= v.waits);
            end else begin
                exec_done = 1'b0;
            end
        end
        exec_done = 1'b0;
        pc_load   = 1'b0;
        check($sformatf("v%0d_timeout", idx), 32'(timed_out), 32'd0);
        check($sformatf("v%0d_lat", idx),  32'(cyc - 1), 32'(v.exp_lat));
        check($sformatf("v%0d_pc", idx),   32'(pc), 32'(v.exp_pc));
        check($sformatf("v%0d_we", idx),   we_mask, v.exp_we);
        check($sformatf("v%0d_fs", idx),   fs_mask, v.exp_fs);
        check($sformatf("v%0d_exec", idx), 32'(exec_cnt), 32'(v.exp_exec));
        $display("vec %0d: ir=%h lat=%0d pc=%h we=%h exec=%0d", idx, v.ir, cyc - 1, pc, we_mask, exec_cnt);
    endtask

    initial begin
        int   exec_seen;
        int   we_cnt;
        int   step_err;
        int   cyc;
        logic hold_ok;

        // 2 steps, LAST on step 1: write_en in cycles 3 and 5, pc 0 -> 1
        vecs[0] = '{8'h12, {24'h0, 24'h0, C_LAST, 24'h0}, 0, 1'b0, 16'h0,
                    16'h0001, 5, 32'h28, 32'h08, 0};
        // Exec bit 1, done after 3 WAIT cycles, jump to ABCD
        vecs[1] = '{8'h34, {24'h0, 24'h0, 24'h0, C_LAST | 24'h2}, 3, 1'b1, 16'hABCD,
                    16'hABCD, 6, 32'h40, 32'h40, 3};
        // Jump to FFFF to set up the wrap
        vecs[2] = '{8'h56, {24'h0, 24'h0, 24'h0, C_LAST}, 0, 1'b1, 16'hFFFF,
                    16'hFFFF, 3, 32'h08, 32'h08, 0};
        // PCC on FFFF wraps to 0000, end of instruction gives 0001
        vecs[3] = '{8'h78, {24'h0, 24'h0, 24'h0, C_LAST | C_PCC}, 0, 1'b0, 16'h0,
                    16'h0001, 3, 32'h08, 32'h08, 0};
        // Full 4 steps, PCC on step 0, exec on step 2 with done in first WAIT
        vecs[4] = '{8'h9A, {24'h0, 24'h000008, 24'h0, C_PCC}, 1, 1'b0, 16'h0,
                    16'h0003, 10, 32'h528, 32'h08, 1};

        // Reset state
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'(ucode_ir), 32'd0);
        check("rst_step", 32'(ucode_step), 32'd0);
        check("rst_exec_req", 32'(exec_req), 32'd0);
        check("rst_write_en", 32'(write_en), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cw_out", 32'(cw_out), 32'(FETCH_CW_DEFAULT));
        $display("reset: pc=%h ir=%h cw_out=%h", pc, ucode_ir, cw_out);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i);

        // HALT with PCC on step 1: pc 3 -> 4 on step 0, frozen afterwards
        ir_in     = 8'hBC;
        rom_cw    = {24'h0, 24'h0, C_HALT | C_PCC, C_PCC};
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc), 32'h0004);
        check("halt_step", 32'(ucode_step), 32'd1);
        check("halt_strobes", {30'd0, write_en, exec_req}, 32'd0);
        check("halt_cw_out", 32'(cw_out), 32'd0);
        hold_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!halted || pc !== 16'h0004 || write_en || exec_req) hold_ok = 1'b0;
        end
        check("halt_hold10", 32'(hold_ok), 32'd1);
        resume = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resume = 1'b0;
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_pc", 32'(pc), 32'h0005);
        check("resume_fetch", 32'(cw_out), 32'(FETCH_CW_DEFAULT));
        check("resume_ir", 32'(ucode_ir), 32'h00BC);
        $display("halt/resume: pc=%h halted=%b cw_out=%h", pc, halted, cw_out);

        // Reset while waiting on the execution unit
        ir_in  = 8'hCD;
        rom_cw = {24'h0, 24'h0, 24'h0, 24'h000004};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("wait_exec_req", 32'(exec_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("wrst_pc", 32'(pc), 32'd0);
        check("wrst_exec_req", 32'(exec_req), 32'd0);
        check("wrst_ir", 32'(ucode_ir), 32'd0);
        check("wrst_cw_out", 32'(cw_out), 32'(FETCH_CW_DEFAULT));
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        exec_done = 1'b1;
        ir_in     = 8'hDE;
        rom_cw    = {24'h0, 24'h0, 24'h0, C_LAST};
        exec_seen = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (exec_req) exec_seen++;
        end
        exec_done = 1'b0;
        check("stray_exec_req", 32'(exec_seen), 32'd0);
        check("stray_pc", 32'(pc), 32'h0001);
        check("stray_ir", 32'(ucode_ir), 32'h00DE);
        check("stray_fetch", 32'(cw_out), 32'(FETCH_CW_DEFAULT));
        $display("reset-in-wait: pc=%h ir=%h exec_seen=%0d", pc, ucode_ir, exec_seen);

        // STEPS=8, no LAST: steps 0..7, eight commits, 17-cycle latency
        rst8     = 1'b0;
        we_cnt   = 0;
        step_err = 0;
        cyc      = 1;
        while (1) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cw_out8 == FETCH_CW_DEFAULT || cyc > 40) break;
            if (write_en8) begin
                if (ucode_step8 !== 3'(we_cnt)) step_err++;
                we_cnt++;
            end
        end
        check("s8_we_count", 32'(we_cnt), 32'd8);
        check("s8_step_order", 32'(step_err), 32'd0);
        check("s8_lat", 32'(cyc - 1), 32'd17);
        check("s8_pc", 32'(pc8), 32'h0001);
        check("s8_ir", 32'(ucode_ir8), 32'h005A);
        $display("steps8: we=%0d lat=%0d pc=%h", we_cnt, cyc - 1, pc8);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/ucode_seq.md
UCODE_SEQ -- requirements
Module: ucode_seq

Interface
REQ-001 Parameter IR_W, default 8: instruction register width.
REQ-002 Parameter PC_W, default 16: program counter width.
REQ-003 Parameter CW_W, default 24: control word width. Bits 21:0 use the existing flag layout; bit 22 is LAST; bit 23 is reserved.
REQ-004 Parameter STEPS, default 4, legal range 2..8: maximum microsteps per instruction.
REQ-005 Parameter EXEC_MASK, default 24'h00001E: control-word bits that require an execution-unit handshake.
REQ-006 Parameter FETCH_CW, default 24'h100200: control word driven during fetch (PCC and ROMO).
REQ-007 clk  input  1  clock; all state changes on rising edge.
REQ-008 rst  input  1  reset; asynchronous, active-high.
REQ-009 ir_in  input  IR_W  instruction byte from the memory bus.
REQ-010 ucode_ir  output  IR_W  registered instruction; addresses the external microcode ROM.
REQ-011 ucode_step  output  $clog2(STEPS)  current microstep index; addresses the external microcode ROM.
REQ-012 cw  input  CW_W  control word for (ucode_ir, ucode_step), combinational from the external ROM.
REQ-013 cw_out  output  CW_W  active control word: FETCH_CW in FETCH, 0 in HALTED, cw otherwise.
REQ-014 exec_req  output  1  execution unit busy request.
REQ-015 exec_done  input  1  execution complete; sampled only in WAIT.
REQ-016 pc_load  input  1  jump taken; sampled only at end of instruction.
REQ-017 pc_load_val  input  PC_W  jump target.
REQ-018 resume  input  1  leave HALTED.
REQ-019 pc  output  PC_W  program counter.
REQ-020 write_en  output  1  register/memory commit strobe.
REQ-021 first_step  output  1  high with write_en when ucode_step==0 (high-bits write enable).
REQ-022 halted  output  1  high in HALTED.

Function
REQ-023 The block SHALL implement states FETCH, STEP, WAIT, EVENTS and HALTED.
REQ-024 FETCH: ir <= ir_in; step <= 0; pc unchanged; next state STEP.
REQ-025 STEP, when cw[21] (HALT) is set: next state HALTED; no pc change. HALT has priority over all other bits.
REQ-026 STEP, otherwise: if cw[20] (PCC) is set, pc <= pc+1.
REQ-027 STEP, otherwise: next state is WAIT if (cw & EXEC_MASK) != 0, else EVENTS.
REQ-028 WAIT: exec_req=1 combinationally for every WAIT cycle. Leave to EVENTS in the cycle exec_done is sampled 1; a done pulse coincident with the first WAIT cycle is accepted. exec_done outside WAIT is ignored.
REQ-029 EVENTS: write_en=1 for exactly one cycle.
REQ-030 EVENTS, end of instruction (cw[22] LAST set, or step==STEPS-1): pc <= pc_load ? pc_load_val : pc+1; next state FETCH.
REQ-031 EVENTS, not end of instruction: step <= step+1; next state STEP.
REQ-032 HALTED: pc, ir and step frozen; exec_req=0; write_en=0. When resume=1: pc <= pc+1, next state FETCH.
REQ-033 pc arithmetic SHALL wrap modulo 2^PC_W (all-ones+1 gives 0).
REQ-034 An instruction without LAST SHALL execute exactly STEPS steps.
REQ-035 Minimum instruction latency is 1+2*steps cycles, plus WAIT cycles.
REQ-036 write_en, exec_req and halted are mutually exclusive per state.

Reset
REQ-037 On rst the block SHALL clear pc, ir and step to 0 and enter FETCH, asynchronously, including mid-WAIT.
REQ-038 During reset: exec_req=0, write_en=0, halted=0, cw_out=FETCH_CW.
REQ-039 The first rising edge after rst deasserts SHALL perform FETCH.

Structure
REQ-040 Package ucode_pkg SHALL hold the state enum, bit indices CW_HALT=21, CW_PCC=20, CW_LAST=22, and default FETCH_CW.
REQ-041 Single module; no sub-module. The microcode ROM stays external so benches drive cw directly.

Verification
REQ-042 Reset, ir_in=8'h12, 2-step instruction with LAST on step 1, no PCC, no exec -> ucode_ir=8'h12; write_en pulses on cycles 3 and 5; FETCH on cycle 6; pc=1.
REQ-043 cw has bit 1 set, exec_done raised after 3 WAIT cycles -> exec_req high exactly 3 cycles, then one write_en; pc_load=1, pc_load_val=16'hABCD at end -> pc=16'hABCD.
REQ-044 pc=16'hFFFF, PCC on step 0, instruction ends -> pc=16'h0001, wrapping through 16'h0000.
REQ-045 HALT with PCC set on step 1 -> halted=1, pc unchanged for 10 cycles; resume pulse -> pc+1, FETCH next cycle.
REQ-046 rst asserted in WAIT -> pc=0, exec_req=0 immediately; a subsequent stray exec_done is ignored.
REQ-047 STEPS=8, LAST never set -> ucode_step runs 0..7, exactly 8 write_en pulses per instruction.
